// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between an ALU (A) and a load (B) writeback source
// Ports:
//   cpu_clk, cpu_rst        clock and synchronous active-high reset
//   a_valid/a_ready/a_rd/a_data  requester A (execute result) handshake
//   b_valid/b_ready/b_rd/b_data  requester B (load data) handshake
//   rf_we/rf_wR/rf_wD       registered register-file write port
//   q_rR1/q_rR2             decode-stage read indices
//   q_hit1/q_hit2           a pending write targets the matching read index
module rf_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wR,
    output logic [DATA_W-1:0] rf_wD,
    input  logic [ADDR_W-1:0] q_rR1,
    input  logic [ADDR_W-1:0] q_rR2,
    output logic              q_hit1,
    output logic              q_hit2
);
    logic              a_full, b_full, b_older;
    logic [ADDR_W-1:0] a_rd_q, b_rd_q;
    logic [DATA_W-1:0] a_data_q, b_data_q;
    logic              grant_a, grant_b, acc_a, acc_b, a_keep, b_keep;

    // Oldest-first: a slot loses only when both are full and the other is older
    assign grant_a = a_full && !(b_full && b_older);
    assign grant_b = b_full && !(a_full && !b_older);
    assign a_ready = !a_full || grant_a;
    assign b_ready = !b_full || grant_b;
    // Writes to x0 complete the handshake but never occupy a slot
    assign acc_a   = a_valid && a_ready && (a_rd != '0);
    assign acc_b   = b_valid && b_ready && (b_rd != '0);
    // Slot that is full and stays full across this edge
    assign a_keep  = a_full && !grant_a;
    assign b_keep  = b_full && !grant_b;

    // The rf_we term covers the write still in flight to the synchronously-read file
    assign q_hit1 = (q_rR1 != '0) && ((a_full && a_rd_q == q_rR1) ||
                                      (b_full && b_rd_q == q_rR1) ||
                                      (rf_we  && rf_wR  == q_rR1));
    assign q_hit2 = (q_rR2 != '0) && ((a_full && a_rd_q == q_rR2) ||
                                      (b_full && b_rd_q == q_rR2) ||
                                      (rf_we  && rf_wR  == q_rR2));

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            a_full  <= 1'b0;
            b_full  <= 1'b0;
            b_older <= 1'b0;
            rf_we   <= 1'b0;
            rf_wR   <= '0;
            rf_wD   <= '0;
        end else begin
            if (acc_a) begin
                a_rd_q   <= a_rd;
                a_data_q <= a_data;
            end
            if (acc_b) begin
                b_rd_q   <= b_rd;
                b_data_q <= b_data;
            end
            a_full  <= acc_a || a_keep;
            b_full  <= acc_b || b_keep;
            // A newcomer is younger than a slot that stays full; a tie goes to B as older
            b_older <= (acc_a && (acc_b || b_keep)) ? 1'b1 :
                       (acc_b && a_keep)            ? 1'b0 : b_older;
            rf_we   <= grant_a || grant_b;
            if (grant_b) begin
                rf_wR <= b_rd_q;
                rf_wD <= b_data_q;
            end else if (grant_a) begin
                rf_wR <= a_rd_q;
                rf_wD <= a_data_q;
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd = '0, b_rd = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        rf_we;
    logic [4:0]  rf_wR;
    logic [31:0] rf_wD;
    logic [4:0]  q_rR1 = '0, q_rR2 = '0;
    logic        q_hit1, q_hit2;
    int          checks = 0;
    int          errors = 0;

    rf_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD),
        .q_rR1(q_rR1), .q_rR2(q_rR2), .q_hit1(q_hit1), .q_hit2(q_hit2)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        // reset held with a pending x5 request
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h5555; q_rR1 = 5'd5; q_rR2 = 5'd5;
        tick(); chk("rst_we0", rf_we, 0);
        tick(); chk("rst_we1", rf_we, 0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_hit1", q_hit1, 0);
        chk("rst_hit2", q_hit2, 0);
        cpu_rst = 1'b0; a_valid = 1'b0;
        tick(); chk("rst_nowr0", rf_we, 0);
        tick(); chk("rst_nowr1", rf_we, 0);

        // single A write
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hDEADBEEF; q_rR1 = 5'd3; q_rR2 = 5'd9;
        chk("sa_ready", a_ready, 1);
        chk("sa_hit_pre", q_hit1, 0);
        tick(); a_valid = 1'b0;
        chk("sa_we_k", rf_we, 0);
        chk("sa_hit_k", q_hit1, 1);
        chk("sa_hit2_k", q_hit2, 0);
        tick();
        chk("sa_we", rf_we, 1);
        chk("sa_wr", rf_wR, 3);
        chk("sa_wd", rf_wD, 32'hDEADBEEF);
        chk("sa_hit_k1", q_hit1, 1);
        tick();
        chk("sa_we_off", rf_we, 0);
        chk("sa_hit_done", q_hit1, 0);

        // simultaneous same-register write
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h1;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h2;
        tick(); a_valid = 1'b0; b_valid = 1'b0;
        chk("sim_a_ready", a_ready, 0);
        chk("sim_b_ready", b_ready, 1);
        tick();
        chk("sim_we0", rf_we, 1);
        chk("sim_wr0", rf_wR, 7);
        chk("sim_wd0", rf_wD, 32'h2);
        chk("sim_a_ready1", a_ready, 1);
        tick();
        chk("sim_we1", rf_we, 1);
        chk("sim_wd1", rf_wD, 32'h1);
        tick();
        chk("sim_we_off", rf_we, 0);

        // mixed-age ordering: B2 accepted before A2, B2 stalled behind older A1
        a_valid = 1'b1; a_rd = 5'd10; a_data = 32'hA1;
        b_valid = 1'b1; b_rd = 5'd11; b_data = 32'hB1;
        tick();
        a_valid = 1'b0; b_rd = 5'd12; b_data = 32'hB2;
        chk("mx_b_ready0", b_ready, 1);
        tick();
        chk("mx_wr_b1", rf_wR, 11);
        b_valid = 1'b0;
        a_valid = 1'b1; a_rd = 5'd13; a_data = 32'hA2;
        chk("mx_a_ready1", a_ready, 1);
        chk("mx_b_stall", b_ready, 0);
        tick(); a_valid = 1'b0;
        chk("mx_wr_a1", rf_wR, 10);
        chk("mx_b_ready2", b_ready, 1);
        chk("mx_a_stall", a_ready, 0);
        tick();
        chk("mx_we_b2", rf_we, 1);
        chk("mx_wd_b2", rf_wD, 32'hB2);
        tick();
        chk("mx_we_a2", rf_we, 1);
        chk("mx_wd_a2", rf_wD, 32'hA2);
        tick();
        chk("mx_we_off", rf_we, 0);

        // x0 filter
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF; q_rR1 = 5'd0;
        chk("x0_ready", a_ready, 1);
        tick(); a_valid = 1'b0;
        chk("x0_we0", rf_we, 0);
        chk("x0_hit", q_hit1, 0);
        chk("x0_ready_after", a_ready, 1);
        tick(); chk("x0_we1", rf_we, 0);
        tick(); chk("x0_we2", rf_we, 0);

        // streaming A rd 1..8
        a_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_rd = 5'(i); a_data = 32'(100 + i);
            chk("st_ready", a_ready, 1);
            tick();
            if (i > 1) begin
                chk("st_we", rf_we, 1);
                chk("st_wr", rf_wR, 32'(i - 1));
                chk("st_wd", rf_wD, 32'(99 + i));
            end
        end
        a_valid = 1'b0;
        tick();
        chk("st_we_last", rf_we, 1);
        chk("st_wr_last", rf_wR, 8);
        tick();
        chk("st_we_off", rf_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port controller for the CPU register file. It shares the file's single write port between two writeback requesters: A (execute/ALU result) and B (load data from memory). Each requester gets a one-entry holding slot, and writes are granted oldest-first. The block also drives a registered write strobe into the register file and reports pending-write hazards for the decode stage's two read indices. It sits between the writeback sources and the register file, and it is the only driver of the file's write port.

## Interface
- `ADDR_W`, 5, register index width
- `DATA_W`, 32, register data width
- `cpu_clk`  in  1  sole clock, rising edge
- `cpu_rst`  in  1  synchronous, active-high reset
- `a_valid`  in  1  requester A has a writeback
- `a_ready`  out  1  A slot can accept this cycle
- `a_rd`  in  ADDR_W  A destination register
- `a_data`  in  DATA_W  A write data
- `b_valid`, `b_ready`, `b_rd`, `b_data`: same as the A signals, for requester B (load)
- `rf_we`  out  1  register-file write enable (registered)
- `rf_wR`  out  ADDR_W  register-file write index (registered)
- `rf_wD`  out  DATA_W  register-file write data (registered)
- `q_rR1`, `q_rR2`  in  ADDR_W  decode-stage read indices
- `q_hit1`, `q_hit2`  out  1  a pending write targets `q_rR1` / `q_rR2` (combinational)

## Operation
- **State:** `a_full`, `a_rd_q`, `a_data_q`; `b_full`, `b_rd_q`, `b_data_q`; age bit `b_older`; output regs `rf_we`, `rf_wR`, `rf_wD`.
- **Handshake:** transfer happens on a rising edge with `x_valid && x_ready`. Data must stay stable while valid is high and ready is low.
- **Ready rule:** `x_ready = !x_full || x_grant`. It depends on slot state only, never on `x_valid`, so there is no combinational loop.
- **x0 filter:** an accepted request with `rd == 0` completes the handshake but is dropped. The slot stays or becomes empty and no `rf_we` results.
- **Grant rule:** evaluated every cycle from slot state.
  - Only A full: grant A. Only B full: grant B.
  - Both full: grant B if `b_older`, else grant A.
- **Age tracking:**
  - On an edge where exactly one slot fills while the other is already full, the already-full slot becomes older.
  - Both fill on the same edge: B is older (the load is the older instruction).
- **Grant edge:**
  - `rf_we <= 1`, `rf_wR <= slot rd`, `rf_wD <= slot data`.
  - The granted slot clears, unless refilled by an accept on the same edge.
- **No grant:** `rf_we <= 0`. `rf_wR` and `rf_wD` hold their values.
- **Throughput:** at most one register-file write per cycle in total. Each slot sustains one write per cycle when uncontended.
- **Hazard query:** `q_hitN = (q_rRN != 0)` and the index matches any of:
  - `a_rd_q` with `a_full`
  - `b_rd_q` with `b_full`
  - `rf_wR` with `rf_we`

  The `rf_we` term is included because the register file reads synchronously, so a same-edge write is not visible to that read.

## Timing
- **Reset (synchronous, wins over all other activity):**
  - Clears `a_full`, `b_full`, `b_older`, `rf_we`, `rf_wR`, `rf_wD` to 0.
  - `a_ready` and `b_ready` read 1 in the cycle after the reset edge.
  - `q_hit1` and `q_hit2` read 0.
  - Reset mid-operation discards held writes; nothing is written.
- **Latency:** handshake at edge k puts the data in the slot. The grant at edge k+1 at the earliest means `rf_we` is high during cycle k+1..k+2, and the file commits at edge k+2.
- **Loser stall:** a slot that loses arbitration holds with `x_ready = 0` until granted.
- **Ordering:** it can take at most one cycle of waiting. Writes to the same `rd` from A and B commit in age order, so the younger value persists.
- **Full and granted:** a full slot that is granted accepts a new request on the same edge (back-to-back).
- **Both empty:** both requesters are accepted on the same edge. B is written first, A one cycle later.

## Test plan
- **Reset:** hold `cpu_rst` for 2 cycles while `a_valid = 1` and `a_rd = 5`, then release. Required: `rf_we = 0` throughout reset, then `a_ready = b_ready = 1`, `q_hit1 = q_hit2 = 0`, and no write of x5 from the request held under reset.
- **Single A write:** A writes x3 = 0xDEADBEEF. Required: exactly one cycle of `rf_we` two edges after the handshake with `rf_wR = 3` and `rf_wD = 0xDEADBEEF`. `q_hit1` is high for `q_rR1 = 3` from the handshake edge until that write commits.
- **Simultaneous same-register write:** A and B both target x7 on the same edge, A = 0x1 and B = 0x2. Required: B is written first (`rf_wD = 0x2`) and A next cycle (0x1). `a_ready = 0` for one cycle.
- **Mixed-age ordering:** B is accepted at edge k, then A at edge k+1 while B is stalled by a forced contention case. Required: B is written before A.
- **x0 filter:** A writes x0 = 0xFFFF. Required: the handshake completes, `rf_we` never rises, and `q_hit1` stays 0 for `q_rR1 = 0`.
- **Streaming:** A is valid for 8 consecutive cycles with `rd` 1..8 and B is idle. Required: `a_ready` stays 1 and there are 8 consecutive `rf_we` cycles carrying `rd` 1..8 in order.
